dmem_byte_ctrl: RTL

DMEM_BYTE_CTRL -- requirements
Module: dmem_byte_ctrl

---
 rtl/dmem_ctrl_pkg.sv | 6 +
 rtl/dmem_rr_arb2.sv | 16 +
 rtl/dmem_byte_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared state encoding and sizing for the byte-wide data memory controller
package dmem_ctrl_pkg;
  localparam int BEATS = 4;
  localparam int ADDR_W_DEF = 10;
  typedef enum logic [1:0] {IDLE, XFER, RTAIL, DONE} state_e;
endpackage

// File: rtl/dmem_rr_arb2.sv
// dmem_rr_arb2: two-way round-robin arbiter, req[0] = pipeline, req[1] = loader
module dmem_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);
  logic r_ptr;
  // a lone requester always wins; on a tie r_ptr picks (0 = pipeline, 1 = loader)
  always_comb gnt = (req == 2'b11) ? (r_ptr ? 2'b10 : 2'b01) : req;
  // after a grant, favour the requester that was not just served
  always_ff @(posedge clk)
    if (!rst_n) r_ptr <= 1'b0;
    else if (upd && |gnt) r_ptr <= gnt[0];
endmodule

// File: rtl/dmem_byte_ctrl.sv
// dmem_byte_ctrl: moves 32-bit big-endian words over a byte-wide memory for two requesters
module dmem_byte_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [31:0]       p_addr,
  input  logic [31:0]       p_wdata,
  output logic [31:0]       p_rdata,
  output logic              p_done,
  output logic              p_stall,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic [31:0]       l_rdata,
  output logic              l_done,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [7:0]        m_wdata,
  input  logic [7:0]        m_rdata,
  output logic              busy,
  output logic              gnt_id
);
  state_e            r_state;
  logic [1:0]        r_beat;
  logic              r_we;
  logic              r_own;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [23:0]       r_rbuf;
  logic [31:0]       r_p_rdata;
  logic [31:0]       r_l_rdata;
  logic              r_p_done;
  logic              r_l_done;
  logic [1:0]        w_gnt;
  logic              w_unused;

  dmem_rr_arb2 u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  ({l_req, p_req}),
    .upd  (r_state == IDLE),
    .gnt  (w_gnt)
  );

  // rst_n also masks the beat issued in the reset cycle so a cut write stops at once
  assign m_en     = (r_state == XFER) && rst_n;
  assign m_we     = m_en && r_we;
  assign m_addr   = r_addr;
  assign m_wdata  = r_wdata[31:24];
  assign busy     = (r_state != IDLE);
  assign gnt_id   = r_own;
  assign p_rdata  = r_p_rdata;
  assign l_rdata  = r_l_rdata;
  assign p_done   = r_p_done;
  assign l_done   = r_l_done;
  assign p_stall  = p_req && !r_p_done;
  assign w_unused = ^{p_addr[31:ADDR_W], l_addr[31:ADDR_W]};

  // transaction sequencer: latch the winner, stream 4 beats, collect read bytes, pulse done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_beat    <= 2'd0;
      r_we      <= 1'b0;
      r_own     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 32'h0;
      r_rbuf    <= 24'h0;
      r_p_rdata <= 32'h0;
      r_l_rdata <= 32'h0;
      r_p_done  <= 1'b0;
      r_l_done  <= 1'b0;
    end else begin
      r_p_done <= 1'b0;
      r_l_done <= 1'b0;
      case (r_state)
        IDLE: if (|w_gnt) begin
          r_state <= XFER;
          r_beat  <= 2'd0;
          r_own   <= w_gnt[1];
          r_we    <= w_gnt[1] ? l_we : p_we;
          r_addr  <= w_gnt[1] ? l_addr[ADDR_W-1:0] : p_addr[ADDR_W-1:0];
          r_wdata <= w_gnt[1] ? l_wdata : p_wdata;
        end
        XFER: begin
          r_beat  <= r_beat + 2'd1;
          r_addr  <= r_addr + ADDR_W'(1);
          r_wdata <= {r_wdata[23:0], 8'h0};
          if (r_beat != 2'd0) r_rbuf <= {r_rbuf[15:0], m_rdata};
          if (r_beat == 2'(BEATS - 1)) begin
            r_state  <= r_we ? DONE : RTAIL;
            r_p_done <= r_we && !r_own;
            r_l_done <= r_we && r_own;
          end
        end
        RTAIL: begin
          r_state  <= DONE;
          r_p_done <= !r_own;
          r_l_done <= r_own;
          if (r_own) r_l_rdata <= {r_rbuf, m_rdata};
          else r_p_rdata <= {r_rbuf, m_rdata};
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
